// File: rtl/arith_pkg.sv
// -----------------------------------------------------------------------------
// arith_pkg
// Shared constants and helpers for the arithmetic library.
//   DSP_LIMB_WIDTH  : width of one unsigned multiplier limb (DSP B-port).
//   DSP_A_MAX_WIDTH : widest unsigned operand one DSP A-port accepts.
//   num_limbs()     : number of DSP limbs needed to cover a given width.
// -----------------------------------------------------------------------------
package arith_pkg;

  localparam int DSP_LIMB_WIDTH  = 17;
  localparam int DSP_A_MAX_WIDTH = 26;

  // Ceiling division of an operand width by the limb width.
  function automatic int num_limbs(input int width);
    return (width + DSP_LIMB_WIDTH - 1) / DSP_LIMB_WIDTH;
  endfunction

endpackage

// File: rtl/mult_limb_stage.sv
// -----------------------------------------------------------------------------
// mult_limb_stage
// One pipeline stage of the chained multiplier. It multiplies a by the lowest
// limb of its b input, adds the previous partial product shifted down by one
// limb, and registers the result. The remaining limbs of b, a, tag and valid
// travel alongside. The low limb of the previous partial product is parked in
// a side vector so all finished low limbs line up with the final stage.
//
// Ports:
//   clk, rst, ce : clock, async active-high reset, clock enable
//   valid_i/o    : operation valid
//   a_i/o        : multiplicand
//   b_i/o        : remaining multiplier limbs (lowest limb consumed here)
//   tag_i/o      : side-band tag
//   carry_i      : partial product of the previous stage (0 for stage 1)
//   p_o          : partial product of this stage
//   lo_i/o       : finished low limbs collected so far
// -----------------------------------------------------------------------------
module mult_limb_stage
  import arith_pkg::*;
#(
  parameter int A_WIDTH   = 24,
  parameter int TAG_WIDTH = 8,
  parameter int NUM_LIMBS = 2,
  parameter int STAGE     = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   ce,
  input  logic                                   valid_i,
  input  logic [A_WIDTH-1:0]                     a_i,
  input  logic [NUM_LIMBS*DSP_LIMB_WIDTH-1:0]    b_i,
  input  logic [TAG_WIDTH-1:0]                   tag_i,
  input  logic [A_WIDTH+DSP_LIMB_WIDTH:0]        carry_i,
  input  logic [NUM_LIMBS*DSP_LIMB_WIDTH-1:0]    lo_i,
  output logic                                   valid_o,
  output logic [A_WIDTH-1:0]                     a_o,
  output logic [NUM_LIMBS*DSP_LIMB_WIDTH-1:0]    b_o,
  output logic [TAG_WIDTH-1:0]                   tag_o,
  output logic [A_WIDTH+DSP_LIMB_WIDTH:0]        p_o,
  output logic [NUM_LIMBS*DSP_LIMB_WIDTH-1:0]    lo_o
);

  localparam int BW   = NUM_LIMBS * DSP_LIMB_WIDTH;
  localparam int PW   = A_WIDTH + DSP_LIMB_WIDTH + 1;
  // Stage k stores the low limb of p_(k-1) in slot k-2.
  localparam int SLOT = (STAGE >= 2) ? (STAGE - 2) : 0;

  logic [PW-1:0] p_d;
  logic [BW-1:0] b_d;
  logic [BW-1:0] lo_d;

  logic          valid_q;
  logic [A_WIDTH-1:0]   a_q;
  logic [BW-1:0]        b_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [PW-1:0]        p_q;
  logic [BW-1:0]        lo_q;

  // Next partial product, limb shift and low-limb collection.
  always_comb begin
    // a*limb + (carry>>17) < 2^(A+18), so PW bits never overflow.
    p_d  = PW'(a_i) * PW'(b_i[DSP_LIMB_WIDTH-1:0]) + (carry_i >> DSP_LIMB_WIDTH);
    b_d  = b_i >> DSP_LIMB_WIDTH;
    lo_d = lo_i;
    if (STAGE >= 2) begin
      lo_d[SLOT*DSP_LIMB_WIDTH +: DSP_LIMB_WIDTH] = carry_i[DSP_LIMB_WIDTH-1:0];
    end else begin
      lo_d = lo_i;
    end
  end

  // Stage register; ce low freezes everything, reset clears data and valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      p_q     <= '0;
      lo_q    <= '0;
    end else if (ce) begin
      valid_q <= valid_i;
      a_q     <= a_i;
      b_q     <= b_d;
      tag_q   <= tag_i;
      p_q     <= p_d;
      lo_q    <= lo_d;
    end
  end

  assign valid_o = valid_q;
  assign a_o     = a_q;
  assign b_o     = b_q;
  assign tag_o   = tag_q;
  assign p_o     = p_q;
  assign lo_o    = lo_q;

endmodule

// File: rtl/int_multiplier_chained.sv
// -----------------------------------------------------------------------------
// int_multiplier_chained
// Fully pipelined unsigned a*b. b is split into 17-bit limbs; each limb is
// handled by one mult_limb_stage. Latency is NUM_LIMBS+1 enabled cycles,
// throughput one operation per enabled cycle, ce=0 stalls the whole pipe.
//
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   ce        : clock enable for every pipeline register
//   in_valid  : a, b, in_tag valid this cycle
//   a, b      : unsigned operands (A_WIDTH, B_WIDTH bits)
//   in_tag    : opaque tag carried with the operation
//   out_valid : result and out_tag valid
//   result    : exact product, A_WIDTH+B_WIDTH bits
//   out_tag   : tag of the operation in result
// -----------------------------------------------------------------------------
module int_multiplier_chained
  import arith_pkg::*;
#(
  parameter int A_WIDTH   = 24,
  parameter int B_WIDTH   = 34,
  parameter int TAG_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ce,
  input  logic                       in_valid,
  input  logic [A_WIDTH-1:0]         a,
  input  logic [B_WIDTH-1:0]         b,
  input  logic [TAG_WIDTH-1:0]       in_tag,
  output logic                       out_valid,
  output logic [A_WIDTH+B_WIDTH-1:0] result,
  output logic [TAG_WIDTH-1:0]       out_tag
);

  localparam int NUM_LIMBS = num_limbs(B_WIDTH);
  localparam int BW = NUM_LIMBS * DSP_LIMB_WIDTH;
  localparam int PW = A_WIDTH + DSP_LIMB_WIDTH + 1;
  localparam int FW = PW + BW - DSP_LIMB_WIDTH;
  localparam int RW = A_WIDTH + B_WIDTH;

  if (A_WIDTH < 1 || A_WIDTH > DSP_A_MAX_WIDTH) begin : g_a_width_check
    $error("int_multiplier_chained: A_WIDTH out of range 1..26");
  end
  if (B_WIDTH < 1 || B_WIDTH > 136) begin : g_b_width_check
    $error("int_multiplier_chained: B_WIDTH out of range 1..136");
  end
  if (TAG_WIDTH < 1 || TAG_WIDTH > 32) begin : g_tag_width_check
    $error("int_multiplier_chained: TAG_WIDTH out of range 1..32");
  end

  // Input (stage 0) registers.
  logic                 valid_q;
  logic [A_WIDTH-1:0]   a_q;
  logic [BW-1:0]        b_q;
  logic [TAG_WIDTH-1:0] tag_q;

  // Per-stage links; index 0 is the input register, index k is stage k.
  logic                 st_valid [0:NUM_LIMBS];
  logic [A_WIDTH-1:0]   st_a     [0:NUM_LIMBS];
  logic [BW-1:0]        st_b     [0:NUM_LIMBS];
  logic [TAG_WIDTH-1:0] st_tag   [0:NUM_LIMBS];
  logic [PW-1:0]        st_p     [0:NUM_LIMBS];
  logic [BW-1:0]        st_lo    [0:NUM_LIMBS];

  logic [FW-1:0]        full_s;

  // Input register; data loads regardless of in_valid, bubbles keep valid low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
    end else if (ce) begin
      valid_q <= in_valid;
      a_q     <= a;
      b_q     <= BW'(b);
      tag_q   <= in_tag;
    end
  end

  assign st_valid[0] = valid_q;
  assign st_a[0]     = a_q;
  assign st_b[0]     = b_q;
  assign st_tag[0]   = tag_q;
  assign st_p[0]     = '0;
  assign st_lo[0]    = '0;

  for (genvar k = 1; k <= NUM_LIMBS; k++) begin : g_stage
    mult_limb_stage #(
      .A_WIDTH   (A_WIDTH),
      .TAG_WIDTH (TAG_WIDTH),
      .NUM_LIMBS (NUM_LIMBS),
      .STAGE     (k)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .ce      (ce),
      .valid_i (st_valid[k-1]),
      .a_i     (st_a[k-1]),
      .b_i     (st_b[k-1]),
      .tag_i   (st_tag[k-1]),
      .carry_i (st_p[k-1]),
      .lo_i    (st_lo[k-1]),
      .valid_o (st_valid[k]),
      .a_o     (st_a[k]),
      .b_o     (st_b[k]),
      .tag_o   (st_tag[k]),
      .p_o     (st_p[k]),
      .lo_o    (st_lo[k])
    );
  end

  // Final partial product on top of the aligned low limbs of earlier stages.
  if (NUM_LIMBS == 1) begin : g_full_one
    assign full_s = st_p[NUM_LIMBS];
  end else begin : g_full_many
    assign full_s = {st_p[NUM_LIMBS], st_lo[NUM_LIMBS][BW-DSP_LIMB_WIDTH-1:0]};
  end

  assign out_valid = st_valid[NUM_LIMBS];
  assign out_tag   = st_tag[NUM_LIMBS];
  // Bits above A_WIDTH+B_WIDTH are zero by construction.
  assign result    = full_s[RW-1:0];

  // Leftovers of the last stage that the result does not need.
  logic unused_s;
  assign unused_s = ^{st_a[NUM_LIMBS], st_b[NUM_LIMBS], st_lo[NUM_LIMBS], full_s[FW-1:RW]};

endmodule

// File: tb/tb_int_multiplier_chained.sv
module tb_int_multiplier_chained;

  logic        clk;
  logic        rst;
  logic        ce;
  logic        in_valid;
  logic [23:0] a;
  logic [33:0] b;
  logic [7:0]  in_tag;
  logic        out_valid;
  logic [57:0] result;
  logic [7:0]  out_tag;

  // 26x17 instance (1 limb)
  logic        in_valid1;
  logic [25:0] a1;
  logic [16:0] b1;
  logic [7:0]  in_tag1;
  logic        out_valid1;
  logic [42:0] result1;
  logic [7:0]  out_tag1;

  // 26x52 instance (4 limbs)
  logic        in_valid2;
  logic [25:0] a2;
  logic [51:0] b2;
  logic [7:0]  in_tag2;
  logic        out_valid2;
  logic [77:0] result2;
  logic [7:0]  out_tag2;

  int_multiplier_chained #(.A_WIDTH(24), .B_WIDTH(34), .TAG_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(a), .b(b), .in_tag(in_tag),
    .out_valid(out_valid), .result(result), .out_tag(out_tag)
  );

  int_multiplier_chained #(.A_WIDTH(26), .B_WIDTH(17), .TAG_WIDTH(8)) dut1 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid1), .a(a1), .b(b1), .in_tag(in_tag1),
    .out_valid(out_valid1), .result(result1), .out_tag(out_tag1)
  );

  int_multiplier_chained #(.A_WIDTH(26), .B_WIDTH(52), .TAG_WIDTH(8)) dut2 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid2), .a(a2), .b(b2), .in_tag(in_tag2),
    .out_valid(out_valid2), .result(result2), .out_tag(out_tag2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [57:0] res;
    logic [7:0]  tag;
    int          due;
  } exp_t;

  exp_t sb_q[$];
  int   en_cnt   = 0;
  int   checks   = 0;
  int   failures = 0;

  // Drive one cycle on the main DUT; on an enabled edge with valid, push the
  // reference product, due two enabled edges after the capturing edge.
  task automatic tick(input logic v, input logic [23:0] av, input logic [33:0] bv,
                      input logic [7:0] tv, input logic cev);
    exp_t e;
    in_valid = v;
    a        = av;
    b        = bv;
    in_tag   = tv;
    ce       = cev;
    @(posedge clk);
    if (cev) begin
      en_cnt++;
      if (v) begin
        e.res = 58'(av) * 58'(bv);
        e.tag = tv;
        e.due = en_cnt + 2;
        sb_q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b1;
    in_valid = 1'b1; a = 24'hABCDEF; b = 34'h1_2345_6789; in_tag = 8'h77;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 58'd0 || out_tag !== 8'd0) begin
      failures++;
      $display("FAIL reset_state: got valid=%b result=%h tag=%h, want 0/0/0", out_valid, result, out_tag);
    end
    checks++;
    if (out_valid1 !== 1'b0 || out_valid2 !== 1'b0) begin
      failures++;
      $display("FAIL reset_state_wide: got valid1=%b valid2=%b, want 0/0", out_valid1, out_valid2);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    sb_q.delete();
  endtask

  task automatic test_basic();
    tick(1'b1, 24'd3, 34'd5, 8'h11, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (i == 3) begin
        if (out_valid !== 1'b1 || result !== 58'd15 || out_tag !== 8'h11) begin
          failures++;
          $display("FAIL basic_3x5: got valid=%b result=%0d tag=%h, want 1/15/11", out_valid, result, out_tag);
        end
      end else if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL basic_latency cycle %0d: got valid=%b, want 0", i, out_valid);
      end
      if (i < 4) tick(1'b0, 24'd0, 34'd0, 8'h00, 1'b1);
    end
  endtask

  task automatic test_max_operands();
    tick(1'b1, 24'hFFFFFF, 34'h3_FFFF_FFFF, 8'h5A, 1'b1);
    tick(1'b0, 24'd0, 34'd0, 8'h00, 1'b1);
    tick(1'b0, 24'd0, 34'd0, 8'h00, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || result !== 58'h03FF_FFFB_FF00_0001 || out_tag !== 8'h5A) begin
      failures++;
      $display("FAIL max_operands: got valid=%b result=%h tag=%h, want 1/03fffffbff000001/5a",
               out_valid, result, out_tag);
    end
    tick(1'b0, 24'd0, 34'd0, 8'h00, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 1004; i++) begin
      if (i < 1000)
        tick(1'b1, 24'($urandom), {2'($urandom), 32'($urandom)}, 8'(i), 1'b1);
      else
        tick(1'b0, 24'($urandom), 34'd0, 8'h00, 1'b1);
      while (sb_q.size() > 0 && sb_q[0].due < en_cnt) void'(sb_q.pop_front());
      checks++;
      if (sb_q.size() > 0 && sb_q[0].due == en_cnt) begin
        if (out_valid !== 1'b1 || result !== sb_q[0].res || out_tag !== sb_q[0].tag) begin
          failures++;
          $display("FAIL back_to_back cycle %0d: got valid=%b result=%h tag=%h, want 1/%h/%h",
                   i, out_valid, result, out_tag, sb_q[0].res, sb_q[0].tag);
        end
      end else if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL back_to_back idle cycle %0d: got valid=%b, want 0", i, out_valid);
      end
    end
    while (sb_q.size() > 0 && sb_q[0].due < en_cnt) void'(sb_q.pop_front());
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL back_to_back_drain: got %0d pending, want 0", sb_q.size());
    end
  endtask

  task automatic test_ce_toggle();
    logic        cev;
    logic [23:0] av;
    logic [33:0] bv;
    logic [7:0]  tv;
    av = 24'($urandom); bv = {2'($urandom), 32'($urandom)}; tv = 8'h80;
    for (int i = 0; i < 600; i++) begin
      cev = ($urandom_range(0, 9) < 3) ? 1'b0 : 1'b1;
      if (i >= 590) cev = 1'b1;
      tick((i < 580) ? 1'b1 : 1'b0, av, bv, tv, cev);
      if (cev) begin
        av = 24'($urandom); bv = {2'($urandom), 32'($urandom)}; tv = tv + 8'd1;
      end
      while (sb_q.size() > 0 && sb_q[0].due < en_cnt) void'(sb_q.pop_front());
      checks++;
      if (sb_q.size() > 0 && sb_q[0].due == en_cnt) begin
        if (out_valid !== 1'b1 || result !== sb_q[0].res || out_tag !== sb_q[0].tag) begin
          failures++;
          $display("FAIL ce_toggle cycle %0d ce=%b: got valid=%b result=%h tag=%h, want 1/%h/%h",
                   i, cev, out_valid, result, out_tag, sb_q[0].res, sb_q[0].tag);
        end
      end else if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL ce_toggle idle cycle %0d ce=%b: got valid=%b, want 0", i, cev, out_valid);
      end
    end
    while (sb_q.size() > 0 && sb_q[0].due < en_cnt) void'(sb_q.pop_front());
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL ce_toggle_drain: got %0d pending, want 0", sb_q.size());
    end
  endtask

  task automatic test_reset_inflight();
    tick(1'b1, 24'h123456, 34'h2_AAAA_5555, 8'hC1, 1'b1);
    tick(1'b1, 24'h654321, 34'h1_5555_AAAA, 8'hC2, 1'b1);
    // Two operations in flight; stall, then reset mid-cycle.
    ce = 1'b0;
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 58'd0 || out_tag !== 8'd0) begin
      failures++;
      $display("FAIL reset_inflight_immediate: got valid=%b result=%h tag=%h, want 0/0/0",
               out_valid, result, out_tag);
    end
    sb_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 24'd0, 34'd0, 8'h00, 1'b1);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_inflight_flush cycle %0d: got valid=%b, want 0", i, out_valid);
      end
    end
    tick(1'b1, 24'd1000, 34'd70000, 8'hD3, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (i == 3) begin
        if (out_valid !== 1'b1 || result !== 58'd70000000 || out_tag !== 8'hD3) begin
          failures++;
          $display("FAIL reset_inflight_new: got valid=%b result=%0d tag=%h, want 1/70000000/d3",
                   out_valid, result, out_tag);
        end
      end else if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_inflight_new_latency cycle %0d: got valid=%b, want 0", i, out_valid);
      end
      if (i < 4) tick(1'b0, 24'd0, 34'd0, 8'h00, 1'b1);
    end
  endtask

  task automatic test_widths();
    int          lat1;
    int          lat2;
    logic [42:0] got1;
    logic [77:0] got2;
    logic [42:0] exp1;
    logic [77:0] exp2;
    logic [7:0]  tag1;
    logic [7:0]  tag2;
    lat1 = 0; lat2 = 0; got1 = '0; got2 = '0; tag1 = '0; tag2 = '0;
    exp1 = ((43'd1 << 26) - 43'd1) * ((43'd1 << 17) - 43'd1);
    exp2 = ((78'd1 << 26) - 78'd1) * ((78'd1 << 52) - 78'd1);
    ce = 1'b1; in_valid = 1'b0;
    in_valid1 = 1'b1; a1 = {26{1'b1}}; b1 = {17{1'b1}}; in_tag1 = 8'hE1;
    in_valid2 = 1'b1; a2 = {26{1'b1}}; b2 = {52{1'b1}}; in_tag2 = 8'hE2;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
      in_valid1 = 1'b0; in_valid2 = 1'b0;
      if (out_valid1 === 1'b1 && lat1 == 0) begin lat1 = e; got1 = result1; tag1 = out_tag1; end
      if (out_valid2 === 1'b1 && lat2 == 0) begin lat2 = e; got2 = result2; tag2 = out_tag2; end
    end
    checks++;
    if (lat1 != 2 || got1 !== exp1 || tag1 !== 8'hE1) begin
      failures++;
      $display("FAIL width_26x17: got latency=%0d result=%h tag=%h, want 2/%h/e1", lat1, got1, tag1, exp1);
    end
    checks++;
    if (lat2 != 5 || got2 !== exp2 || tag2 !== 8'hE2) begin
      failures++;
      $display("FAIL width_26x52: got latency=%0d result=%h tag=%h, want 5/%h/e2", lat2, got2, tag2, exp2);
    end
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; in_valid = 1'b0; a = '0; b = '0; in_tag = '0;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; in_tag1 = '0;
    in_valid2 = 1'b0; a2 = '0; b2 = '0; in_tag2 = '0;
    #1;
    test_reset();
    test_basic();
    test_max_operands();
    test_back_to_back();
    test_ce_toggle();
    test_reset_inflight();
    test_widths();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/int_multiplier_chained.md
# int_multiplier_chained

Parametrised, fully pipelined unsigned integer multiplier for the shared arithmetic library. B is split into 17-bit limbs, each multiplied by A in its own DSP-sized stage and accumulated with the previous stage's shifted partial product. Adds what the fixed-width multipliers lack: arbitrary operand widths, a valid/tag side-band, a global clock enable for stalling, and reset. Sits under the NTT butterflies and modular reducers wherever operand widths vary by configuration.

## Interface
- A_WIDTH, 24, width of operand a; legal range 1..26, one DSP A-port.
- B_WIDTH, 34, width of operand b; 1..136.
- TAG_WIDTH, 8, width of the side-band tag; 1..32.
- NUM_LIMBS, derived, ceil(B_WIDTH/17); not overridable.
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- ce  in  1  clock enable; 0 freezes every register in the pipeline.
- in_valid  in  1  a, b, in_tag are valid this cycle.
- a  in  A_WIDTH  unsigned multiplicand.
- b  in  B_WIDTH  unsigned multiplier.
- in_tag  in  TAG_WIDTH  opaque tag travelling with the operands.
- out_valid  out  1  result and out_tag are valid.
- result  out  A_WIDTH+B_WIDTH  a*b, exact.
- out_tag  out  TAG_WIDTH  in_tag of the same operation.

## Operation
- b is zero-extended to NUM_LIMBS*17 bits; limb j = b[17j+16:17j].
- Stage 0 (input register): captures a, b, in_tag, in_valid.
- Stage k, k=1..NUM_LIMBS: p_k = a * limb(k-1) + (p_(k-1) >> 17), p_0 = 0; p_k is A_WIDTH+18 bits wide and cannot overflow.
- a, the remaining limbs, tag and valid advance one stage per enabled cycle alongside p_k.
- p_k[16:0] (k<NUM_LIMBS) enters a per-limb delay line so all low limbs align with p_NUM_LIMBS.
- result = {p_NUM_LIMBS, low limbs k=NUM_LIMBS-1..1}, truncated to A_WIDTH+B_WIDTH bits; truncated bits are 0 by construction.
- Data registers load regardless of in_valid (bubbles carry garbage but out_valid=0); valid bits are reset, data registers are also reset to 0.
- No backpressure other than ce: the caller drops ce to stall; no handshake ready.

## Timing
- Latency NUM_LIMBS+1 enabled cycles from in_valid sampled high (ce=1) to out_valid high; 3 cycles for defaults.
- Throughput one operation per enabled cycle.
- ce=0: all outputs hold; inputs ignored; in_valid while ce=0 is lost (caller's responsibility).
- Back-to-back valid inputs produce back-to-back outputs in order.
- Reset (async assert, sync-safe deassert by caller): out_valid=0, result=0, out_tag=0 immediately; in-flight operations discarded, no partial outputs after release.
- Reset while ce=0: still clears.

## Structure
- Shared package arith_pkg: DSP_LIMB_WIDTH=17, DSP_A_MAX_WIDTH=26, function num_limbs(width).
- Sub-module mult_limb_stage (one per limb, generate loop): registered a*limb + carry_in>>17, passes a, remaining b, tag, valid; ce and rst inputs.
- Elaboration-time assertion on A_WIDTH and B_WIDTH ranges.

## Test plan
- Defaults, a=3, b=5, in_tag=0x11 one cycle -> out_valid high exactly 3 cycles later, result=15, out_tag=0x11.
- Defaults, a=0xFFFFFF, b=0x3_FFFF_FFFF -> result=0x03FF_FFFB_FF00_0001.
- Defaults, 1000 back-to-back random pairs with incrementing tags -> in-order outputs on consecutive cycles, all matching reference product.
- Random ce toggling (~30% low) during streaming -> outputs identical to ce=1 stream, latency counted in enabled cycles only.
- Reset asserted with 2 operations in flight -> out_valid, result, out_tag 0 within the same cycle; no out_valid after release until a new input plus 3 cycles.
- A_WIDTH=26, B_WIDTH=17 (1 limb, latency 2) and B_WIDTH=52 (4 limbs, latency 5), all-ones operands -> exact products (2^26-1)(2^B-1).
